imem_uart_loader: RTL and testbench
===================================

// Module: imem_uart_loader
// PURPOSE
//  Receives a program image over a UART serial line and writes it word-by-word into instruction
//  memory through a write port (wren/addr/data), the write-side counterpart of the processor's
//  imem read path. Holds the processor in reset while loading and releases it when done.
//  Sits beside the processor and instruction memory in the top-level wrapper.
//  Frame: magic byte 0xA5, 16-bit word count N (MSB byte first), then 4*N data bytes
//  (each word MSB byte first).
// PARAMETERS
//  CLKS_PER_BIT  434   clock cycles per UART bit (50 MHz / 115200 baud); must be >= 4
//  MAGIC         8'hA5 start-of-load byte
// PORTS
//  clock       in   1   system clock; all state updates on rising edge
//  reset       in   1   synchronous, active-low reset (0 = reset)
//  uart_rx     in   1   asynchronous serial input, idle high, 8N1, LSB first
//  imem_wren   out  1   one-cycle write strobe to instruction memory
//  imem_addr   out  12  word address of current write
//  imem_data   out  32  word being written
//  cpu_hold    out  1   1 = hold processor in reset during load
//  load_done   out  1   1 = last load completed successfully (sticky)
//  load_error  out  1   1 = last load aborted (framing or count error; sticky)
// BEHAVIOUR
//  Reset (reset==0 at clock edge): all outputs 0; FSM IDLE; byte/word/addr counters 0;
//   rx synchronizer flops set to 1. Reset mid-load abandons the load; no further writes.
//  RX front end: 2-flop synchronizer on uart_rx. Falling edge while idle starts a frame;
//   re-sample at CLKS_PER_BIT/2: if high, false start, return to idle. Then 8 data bits
//   sampled every CLKS_PER_BIT, LSB first; stop bit sampled at next interval.
//   Stop==1 -> byte_valid pulse (1 cycle); stop==0 -> frame_err pulse (1 cycle), byte dropped.
//  FSM (advances only on byte_valid/frame_err):
//   IDLE: byte==MAGIC -> CNT_HI; cpu_hold<=1; load_done<=0; load_error<=0. Other bytes and
//    frame_err ignored.
//   CNT_HI: store count[15:8] -> CNT_LO.
//   CNT_LO: store count[7:0]; count==0 -> DONE; count>4096 -> ERROR; else addr<=0 -> DATA.
//   DATA: shift byte into word register (MSB first). On 4th byte: next cycle imem_wren=1
//    with imem_data=word, imem_addr=current addr; addr increments after strobe. After
//    N-th word strobe -> DONE. N==4096 writes addresses 0..4095; addr wraps to 0, no extra write.
//   DONE: cpu_hold<=0, load_done<=1 -> IDLE.
//   ERROR: load_error<=1, cpu_hold stays 1 -> IDLE (processor held until next good load).
//  frame_err in CNT_HI/CNT_LO/DATA -> ERROR; partially written words stay in memory.
//  MAGIC byte inside CNT_*/DATA is data, not a restart.
//  imem_wren is never high two consecutive cycles; imem_addr/imem_data hold last values between
//   strobes. Write latency: strobe exactly 1 cycle after the byte_valid of the 4th byte.
//  Byte latency: byte_valid occurs ~ (9.5*CLKS_PER_BIT + 2) cycles after start-bit edge.
// TESTING (bench uses CLKS_PER_BIT=16)
//  1 Reset held low 5 cycles with rx toggling -> all outputs 0, no imem_wren.
//  2 Send A5,00,02,DE,AD,BE,EF,01,23,45,67 -> writes addr0=DEADBEEF, addr1=01234567, exactly
//    2 strobes; cpu_hold 1 from A5 to end; then load_done=1, cpu_hold=0.
//  3 Send 3C then A5,00,00 -> 3C ignored; no writes; load_done=1, cpu_hold=0.
//  4 Send A5,00,01,11,22 then frame with stop bit 0 -> load_error=1, cpu_hold=1, no write;
//    then valid A5,00,01,AA,BB,CC,DD -> addr0=AABBCCDD, load_error=0, load_done=1.
//  5 Send A5,10,01 (count 4097) -> load_error=1, no writes; 1-cycle-wide rx low glitch in
//    IDLE -> no byte_valid, state unchanged.
//  6 Assert reset mid-DATA after 2 bytes -> outputs 0, no strobe; next A5 load succeeds.

Source files
------------

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port driven by the UART loader.
// The loader drives it through the master modport.
// The instruction memory, or a monitor, observes it through the slave modport.
interface imem_uart_loader_if;
    logic        wren;
    logic [11:0] addr;
    logic [31:0] data;

    modport master (output wren, output addr, output data);
    modport slave  (input  wren, input  addr, input  data);
endinterface

// File: rtl/imem_uart_loader.sv
// UART program loader.
// It receives the frame: magic byte, 16-bit word count (MSB first), then 4*N data bytes.
// It writes each assembled 32-bit word into instruction memory.
// The processor is held in reset while a load is in progress, and after a failed load.
module imem_uart_loader #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] MAGIC        = 8'hA5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                uart_rx,
    imem_uart_loader_if.master  imem,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_error
);
    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {L_IDLE, L_CNT_HI, L_CNT_LO, L_DATA, L_DONE, L_ERROR} ld_state_t;

    rx_state_t     rx_state_r, rx_next_s;
    ld_state_t     ld_state_r, ld_next_s;
    logic          rx_meta_r, rx_sync_r, rx_prev_r;
    logic [CW-1:0] clk_cnt_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r, rx_byte_r;
    logic          byte_valid_r, frame_err_r;
    logic          tick_half_s, tick_full_s;
    logic [15:0]   count_r, cnt_full_s;
    logic [12:0]   words_r;
    logic [11:0]   addr_r, addr_out_r;
    logic [1:0]    byte_idx_r;
    logic [31:0]   word_r, data_out_r;
    logic          wren_r, hold_r, done_r, err_r;
    logic          last_byte_s, last_word_s, magic_s;

    // Next-state logic of the UART receiver.
    always_comb begin
        rx_next_s   = rx_state_r;
        tick_half_s = (clk_cnt_r == HALF_M1);
        tick_full_s = (clk_cnt_r == FULL_M1);
        case (rx_state_r)
            RX_IDLE: begin
                if (rx_prev_r && !rx_sync_r) rx_next_s = RX_START;
                else                         rx_next_s = RX_IDLE;
            end
            RX_START: begin
                if (tick_half_s) rx_next_s = rx_sync_r ? RX_IDLE : RX_DATA;
                else             rx_next_s = RX_START;
            end
            RX_DATA: begin
                if (tick_full_s && (bit_cnt_r == 3'd7)) rx_next_s = RX_STOP;
                else                                    rx_next_s = RX_DATA;
            end
            RX_STOP: begin
                if (tick_full_s) rx_next_s = RX_IDLE;
                else             rx_next_s = RX_STOP;
            end
            default: rx_next_s = RX_IDLE;
        endcase
    end

    // State register of the UART receiver.
    always_ff @(posedge clock) begin
        if (!reset) rx_state_r <= RX_IDLE;
        else        rx_state_r <= rx_next_s;
    end

    // Receiver datapath: synchronizer, bit timing, shift register, and byte/error pulses.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta_r    <= 1'b1;
            rx_sync_r    <= 1'b1;
            rx_prev_r    <= 1'b1;
            clk_cnt_r    <= '0;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'd0;
            rx_byte_r    <= 8'd0;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            rx_meta_r    <= uart_rx;
            rx_sync_r    <= rx_meta_r;
            rx_prev_r    <= rx_sync_r;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    clk_cnt_r <= '0;
                    bit_cnt_r <= 3'd0;
                end
                RX_START: begin
                    if (tick_half_s) clk_cnt_r <= '0;
                    else             clk_cnt_r <= clk_cnt_r + 1'b1;
                end
                RX_DATA: begin
                    if (tick_full_s) begin
                        clk_cnt_r <= '0;
                        shift_r   <= {rx_sync_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (tick_full_s) begin
                        clk_cnt_r <= '0;
                        if (rx_sync_r) begin
                            byte_valid_r <= 1'b1;
                            rx_byte_r    <= shift_r;
                        end else begin
                            frame_err_r  <= 1'b1;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 1'b1;
                    end
                end
                default: clk_cnt_r <= '0;
            endcase
        end
    end

    // Next-state logic of the frame parser; it only moves on a received byte or a framing error.
    always_comb begin
        ld_next_s   = ld_state_r;
        cnt_full_s  = {count_r[15:8], rx_byte_r};
        last_byte_s = (byte_idx_r == 2'd3);
        last_word_s = (({3'b000, words_r} + 16'd1) == count_r);
        magic_s     = (rx_byte_r == MAGIC);
        case (ld_state_r)
            L_IDLE: begin
                if (byte_valid_r && magic_s) ld_next_s = L_CNT_HI;
                else                         ld_next_s = L_IDLE;
            end
            L_CNT_HI: begin
                if (frame_err_r)       ld_next_s = L_ERROR;
                else if (byte_valid_r) ld_next_s = L_CNT_LO;
                else                   ld_next_s = L_CNT_HI;
            end
            L_CNT_LO: begin
                if (frame_err_r)                 ld_next_s = L_ERROR;
                else if (!byte_valid_r)          ld_next_s = L_CNT_LO;
                else if (cnt_full_s == 16'd0)    ld_next_s = L_DONE;
                else if (cnt_full_s > 16'd4096)  ld_next_s = L_ERROR;
                else                             ld_next_s = L_DATA;
            end
            L_DATA: begin
                if (frame_err_r)                                    ld_next_s = L_ERROR;
                else if (byte_valid_r && last_byte_s && last_word_s) ld_next_s = L_DONE;
                else                                                ld_next_s = L_DATA;
            end
            L_DONE:  ld_next_s = L_IDLE;
            L_ERROR: ld_next_s = L_IDLE;
            default: ld_next_s = L_IDLE;
        endcase
    end

    // State register of the frame parser.
    always_ff @(posedge clock) begin
        if (!reset) ld_state_r <= L_IDLE;
        else        ld_state_r <= ld_next_s;
    end

    // Parser datapath: count capture, word assembly, write strobe, and status flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_r    <= 16'd0;
            words_r    <= 13'd0;
            addr_r     <= 12'd0;
            addr_out_r <= 12'd0;
            byte_idx_r <= 2'd0;
            word_r     <= 32'd0;
            data_out_r <= 32'd0;
            wren_r     <= 1'b0;
            hold_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            wren_r <= 1'b0;
            case (ld_state_r)
                L_IDLE: begin
                    if (byte_valid_r && magic_s) begin
                        hold_r <= 1'b1;
                        done_r <= 1'b0;
                        err_r  <= 1'b0;
                    end
                end
                L_CNT_HI: begin
                    if (byte_valid_r) count_r[15:8] <= rx_byte_r;
                end
                L_CNT_LO: begin
                    if (byte_valid_r) begin
                        count_r[7:0] <= rx_byte_r;
                        addr_r       <= 12'd0;
                        words_r      <= 13'd0;
                        byte_idx_r   <= 2'd0;
                    end
                end
                L_DATA: begin
                    if (byte_valid_r) begin
                        word_r     <= {word_r[23:0], rx_byte_r};
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (last_byte_s) begin
                            // A 4096-word image wraps addr_r back to 0 without issuing an extra write.
                            wren_r     <= 1'b1;
                            data_out_r <= {word_r[23:0], rx_byte_r};
                            addr_out_r <= addr_r;
                            addr_r     <= addr_r + 12'd1;
                            words_r    <= words_r + 13'd1;
                        end
                    end
                end
                L_DONE: begin
                    hold_r <= 1'b0;
                    done_r <= 1'b1;
                end
                L_ERROR: begin
                    err_r <= 1'b1;
                end
                default: wren_r <= 1'b0;
            endcase
        end
    end

    assign imem.wren  = wren_r;
    assign imem.addr  = addr_out_r;
    assign imem.data  = data_out_r;
    assign cpu_hold   = hold_r;
    assign load_done  = done_r;
    assign load_error = err_r;
endmodule

// File: tb/tb_imem_uart_loader.sv
// Scoreboard bench for imem_uart_loader.
// Serial bytes are driven onto uart_rx.
// A frame-level reference model predicts the memory writes and the status flags.
// A monitor checks every write strobe against the queue of expected writes.
module tb_imem_uart_loader;
    localparam int CPB = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic uart_rx = 1'b1;
    logic cpu_hold, load_done, load_error;

    imem_uart_loader_if imem_bus ();

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .MAGIC(8'hA5)) dut (
        .clock      (clock),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .imem       (imem_bus),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [43:0] exp_q[$];
    logic [7:0]  tx_q[$];
    logic        prev_wren = 1'b0;

    // Reference model state, expressed in terms of the frame layout.
    int          m_phase = 0;   // 0 waiting for magic, 1 count high, 2 count low, 3 payload
    int          m_cnt = 0;
    int          m_nbytes = 0;
    int          m_addr = 0;
    logic [31:0] m_word = 32'd0;
    logic        m_hold = 1'b0;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;

    // Monitor: every strobe must match the oldest expected write, and strobes never occur back to back.
    always @(negedge clock) begin
        if (imem_bus.wren === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", imem_bus.addr, imem_bus.data);
            end else begin
                logic [43:0] e;
                e = exp_q.pop_front();
                if ({imem_bus.addr, imem_bus.data} !== e)
                begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h", imem_bus.addr, imem_bus.data, e[43:32], e[31:0]);
                end
            end
            checks++;
            if (prev_wren) begin
                errors++;
                $display("FAIL wren_back_to_back: got wren high on 2 consecutive cycles, expected 1");
            end
        end
        prev_wren = imem_bus.wren;
    end

    task automatic model_rx(input logic [7:0] b, input bit good);
        if (!good) begin
            if (m_phase != 0) begin
                m_phase = 0;
                m_err = 1'b1;
            end
        end else begin
            case (m_phase)
                0: if (b == 8'hA5) begin
                    m_phase = 1; m_hold = 1'b1; m_done = 1'b0; m_err = 1'b0;
                end
                1: begin m_cnt = int'(b) * 256; m_phase = 2; end
                2: begin
                    m_cnt = m_cnt + int'(b);
                    if (m_cnt == 0) begin
                        m_done = 1'b1; m_hold = 1'b0; m_phase = 0;
                    end else if (m_cnt > 4096) begin
                        m_err = 1'b1; m_phase = 0;
                    end else begin
                        m_addr = 0; m_nbytes = 0; m_phase = 3;
                    end
                end
                3: begin
                    m_word = {m_word[23:0], b};
                    m_nbytes++;
                    if (m_nbytes % 4 == 0) begin
                        exp_q.push_back({12'(m_addr), m_word});
                        m_addr = (m_addr + 1) % 4096;
                        if (m_nbytes / 4 == m_cnt) begin
                            m_done = 1'b1; m_hold = 1'b0; m_phase = 0;
                        end
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic check_flags(input string name);
        checks++;
        if ({cpu_hold, load_done, load_error} !== {m_hold, m_done, m_err}) begin
            errors++;
            $display("FAIL %s: got hold/done/err=%b%b%b, expected %b%b%b", name, cpu_hold, load_done, load_error, m_hold, m_done, m_err);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d pending writes, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // The model is updated when the byte is issued, so expected writes are queued before the DUT strobes.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        model_rx(b, stop_ok);
        @(negedge clock);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rx = stop_ok;
        repeat (CPB) @(negedge clock);
        uart_rx = 1'b1;
        repeat (4 + $urandom_range(0, 3)) @(negedge clock);
        check_flags("flags_after_byte");
    endtask

    task automatic send_queued();
        while (tx_q.size() != 0) send_byte(tx_q.pop_front(), 1'b1);
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            uart_rx = i[0];
            @(negedge clock);
            checks++;
            if ({cpu_hold, load_done, load_error, imem_bus.wren} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs: got hold/done/err/wren=%b%b%b%b, expected 0000", cpu_hold, load_done, load_error, imem_bus.wren);
            end
        end
        uart_rx = 1'b1;
        m_phase = 0; m_hold = 1'b0; m_done = 1'b0; m_err = 1'b0;
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_flags("flags_after_reset");
    endtask

    initial begin
        // 1: reset held low with rx toggling
        do_reset(5);

        // 2: two-word load
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        send_queued();
        check_drained("two_word_load");

        // 3: junk byte, then a zero-length load
        tx_q = '{8'h3C, 8'hA5, 8'h00, 8'h00};
        send_queued();
        check_drained("zero_count_load");

        // 4: framing error mid-payload, then a good load
        tx_q = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22};
        send_queued();
        send_byte(8'h33, 1'b0);
        check_drained("frame_error_load");
        tx_q = '{8'hA5, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_queued();
        check_drained("recovery_load");

        // 5: count above the memory depth, then a one-cycle glitch while idle
        tx_q = '{8'hA5, 8'h10, 8'h01};
        send_queued();
        @(negedge clock);
        uart_rx = 1'b0;
        @(negedge clock);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        check_flags("flags_after_glitch");

        // Largest legal count: one word is written at address 0 before the load is abandoned.
        tx_q = '{8'hA5, 8'h10, 8'h00, 8'h5A, 8'hA5, 8'hC3, 8'h3C};
        send_queued();
        check_drained("count_4096_first_word");

        // 6: reset after two payload bytes, then a fresh load
        tx_q = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34};
        send_queued();
        do_reset(3);
        tx_q = '{8'hA5, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        send_queued();
        check_drained("load_after_reset");

        // Randomized loads with junk bytes and idle framing errors in front.
        for (int r = 0; r < 6; r++) begin
            int junk;
            int n;
            junk = $urandom_range(0, 2);
            for (int j = 0; j < junk; j++) begin
                logic [7:0] jb;
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h5A;
                send_byte(jb, 1'($urandom_range(0, 1)));
            end
            n = $urandom_range(0, 4);
            tx_q.push_back(8'hA5);
            tx_q.push_back(8'h00);
            tx_q.push_back(8'(n));
            for (int k = 0; k < 4 * n; k++) tx_q.push_back(8'($urandom_range(0, 255)));
            send_queued();
            check_drained("random_load");
        end

        repeat (20) @(negedge clock);
        check_drained("final_drain");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
